alkmdseq: RTL and testbench

ALKMDSEQ -- requirements
Module: alkmdseq

---
 rtl/alkmdseq.sv | 139 +++++++++++++
 tb/tb_alkmdseq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alkmdseq.sv
// ALK multiply/divide step sequencer: drives the ALPCTL shift-in controls and stalls microcode.
// Optional build macro ALKMDSEQ_EARLYOUT_EN ends a multiply early once the remaining multiplier bits are zero.
module alkmdseq #(
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             mul_req_h,
    input  logic             div_req_h,
    input  logic             divdbl_req_h,
    input  logic             rem_req_h,
    input  logic [1:0]       size_h,
    input  logic             q_lsb_h,
    input  logic             q_zero_h,
    input  logic             alu_sout_h,
    input  logic             abort_h,
    output logic             alpctl_mul_l,
    output logic             alpctl_div_l,
    output logic             alpctl_divdbl_l,
    output logic             alpctl_rem_l,
    output logic             loopf_h,
    output logic             aluso_h,
    output logic             busy_h,
    output logic             stall_h,
    output logic             done_h,
    output logic [CNT_W-1:0] step_h
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DIVDBL,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] n_steps;
    logic             loopf_q;
    logic             aluso_q;
    logic             rem_q;
    logic             accept;
    logic             stepping;
    logic             early_out;
    logic             last_step;

    always_comb begin
        case (size_h)
            2'b00:   n_steps = CNT_W'(8);
            2'b01:   n_steps = CNT_W'(16);
            default: n_steps = CNT_W'(32);
        endcase
    end

`ifdef ALKMDSEQ_EARLYOUT_EN
    assign early_out = (state == S_MUL) && q_zero_h && !loopf_q;
`else
    logic unused_q_zero;
    assign unused_q_zero = q_zero_h;
    assign early_out     = 1'b0;
`endif

    assign stepping  = (state == S_MUL) || (state == S_DIV) || (state == S_DIVDBL);
    assign last_step = stepping && ((cnt == CNT_W'(1)) || early_out);

    always_ff @(posedge clk_h) begin
        if (reset_h) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state      = state;
        accept          = 1'b0;
        busy_h          = 1'b0;
        stall_h         = 1'b0;
        done_h          = 1'b0;
        alpctl_mul_l    = (state != S_MUL);
        alpctl_div_l    = (state != S_DIV);
        alpctl_divdbl_l = (state != S_DIVDBL);
        alpctl_rem_l    = (state != S_FIX);
        case (state)
            S_IDLE: begin
                accept = divdbl_req_h || div_req_h || mul_req_h;
                if (divdbl_req_h)   next_state = S_DIVDBL;
                else if (div_req_h) next_state = S_DIV;
                else if (mul_req_h) next_state = S_MUL;
            end
            S_MUL, S_DIV, S_DIVDBL: begin
                busy_h = 1'b1;
                // With a remainder fixup pending, FIX is the final step, not this one.
                stall_h = !(last_step && !rem_q);
                if (abort_h)        next_state = S_IDLE;
                else if (last_step) next_state = rem_q ? S_FIX : S_DONE;
            end
            S_FIX: begin
                busy_h     = 1'b1;
                next_state = abort_h ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_h     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            cnt      <= '0;
            step_cnt <= '0;
            loopf_q  <= 1'b0;
            aluso_q  <= 1'b0;
            rem_q    <= 1'b0;
        end else if (busy_h && abort_h) begin
            loopf_q <= 1'b0;
            aluso_q <= 1'b0;
            rem_q   <= 1'b0;
        end else if (accept) begin
            cnt      <= n_steps;
            step_cnt <= '0;
            aluso_q  <= 1'b0;
            loopf_q  <= q_lsb_h;
            rem_q    <= rem_req_h && (divdbl_req_h || div_req_h);
        end else if (stepping) begin
            cnt      <= cnt - CNT_W'(1);
            step_cnt <= step_cnt + CNT_W'(1);
            if (state == S_MUL) loopf_q <= q_lsb_h;
            else                aluso_q <= alu_sout_h;
        end
    end

    assign loopf_h = loopf_q;
    assign aluso_h = aluso_q;
    assign step_h  = step_cnt;

endmodule

// File: tb/tb_alkmdseq.sv
// Self-checking bench for alkmdseq: directed scenario table plus randomized traffic
// checked every cycle against a schedule-queue reference model.
module tb_alkmdseq;

    logic       clk_h = 1'b0;
    logic       reset_h = 1'b1;
    logic       mul_req_h = 1'b0, div_req_h = 1'b0, divdbl_req_h = 1'b0, rem_req_h = 1'b0;
    logic [1:0] size_h = 2'b00;
    logic       q_lsb_h = 1'b0, q_zero_h = 1'b0, alu_sout_h = 1'b0, abort_h = 1'b0;
    logic       alpctl_mul_l, alpctl_div_l, alpctl_divdbl_l, alpctl_rem_l;
    logic       loopf_h, aluso_h, busy_h, stall_h, done_h;
    logic [5:0] step_h;

`ifdef ALKMDSEQ_EARLYOUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    alkmdseq #(.CNT_W(6)) dut (
        .clk_h(clk_h), .reset_h(reset_h),
        .mul_req_h(mul_req_h), .div_req_h(div_req_h), .divdbl_req_h(divdbl_req_h),
        .rem_req_h(rem_req_h), .size_h(size_h), .q_lsb_h(q_lsb_h), .q_zero_h(q_zero_h),
        .alu_sout_h(alu_sout_h), .abort_h(abort_h),
        .alpctl_mul_l(alpctl_mul_l), .alpctl_div_l(alpctl_div_l),
        .alpctl_divdbl_l(alpctl_divdbl_l), .alpctl_rem_l(alpctl_rem_l),
        .loopf_h(loopf_h), .aluso_h(aluso_h), .busy_h(busy_h), .stall_h(stall_h),
        .done_h(done_h), .step_h(step_h)
    );

    always #5 clk_h = ~clk_h;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model: a queue of planned cycles. 0 idle, 1 mul step, 2 div step,
    // 3 divdbl step, 4 remainder fixup, 5 done pulse.
    int plan[$];
    int m_step = 0;
    bit m_loopf = 1'b0;
    bit m_aluso = 1'b0;

    bit       obs_done, obs_rem, obs_aluso;
    int       obs_step;

    function automatic int cur_kind();
        return (plan.size() > 0) ? plan[0] : 0;
    endfunction

    function automatic logic [14:0] expected();
        int c = cur_kind();
        bit busy = (c >= 1) && (c <= 4);
        bit fin;
        fin = (c == 4)
           || ((c >= 1) && (c <= 3) && (plan.size() > 1) && (plan[1] == 5))
           || ((c == 1) && EO && q_zero_h && !m_loopf);
        return {c != 1, c != 2, c != 3, c != 4, m_loopf, m_aluso,
                busy, busy && !fin, c == 5, 6'(m_step)};
    endfunction

    function automatic void update();
        int c = cur_kind();
        if (reset_h) begin
            plan.delete(); m_step = 0; m_loopf = 0; m_aluso = 0;
        end else if (c == 0) begin
            if (divdbl_req_h || div_req_h || mul_req_h) begin
                int k = divdbl_req_h ? 3 : (div_req_h ? 2 : 1);
                int n = (size_h == 2'b00) ? 8 : ((size_h == 2'b01) ? 16 : 32);
                for (int i = 0; i < n; i++) plan.push_back(k);
                if (rem_req_h && k != 1) plan.push_back(4);
                plan.push_back(5);
                m_step = 0; m_aluso = 0; m_loopf = q_lsb_h;
            end
        end else if (c <= 4 && abort_h) begin
            plan.delete(); m_loopf = 0; m_aluso = 0;
        end else if (c <= 3) begin
            bit eo = (c == 1) && EO && q_zero_h && !m_loopf;
            m_step++;
            if (c == 1) m_loopf = q_lsb_h;
            else        m_aluso = alu_sout_h;
            void'(plan.pop_front());
            if (eo) begin
                plan.delete();
                plan.push_back(5);
            end
        end else begin
            void'(plan.pop_front());
        end
    endfunction

    task automatic tick();
        logic [14:0] got, exp;
        @(negedge clk_h); #1;
        got = {alpctl_mul_l, alpctl_div_l, alpctl_divdbl_l, alpctl_rem_l,
               loopf_h, aluso_h, busy_h, stall_h, done_h, step_h};
        exp = expected();
        obs_done  = done_h;
        obs_rem   = !alpctl_rem_l;
        obs_aluso = aluso_h;
        obs_step  = int'(step_h);
        if (chk_en) begin
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL outs cyc=%0d got=%h exp=%h (mul div dbl rem loopf aluso busy stall done step)",
                         cyc, got, exp);
            end
        end
        @(posedge clk_h); #1;
        update();
        cyc++;
    endtask

    // kind: 1 mul, 2 div, 3 divdbl, 7 all three requests
    typedef struct {
        int         kind;
        logic [1:0] size;
        bit         rem;
        bit         hold;
        bit         early;
        int         abort_at;
        int         reset_at;
        int         exp_done;
        int         exp_step;
    } scn_t;

    scn_t scns[9];

    task automatic run_scn(input int idx, input scn_t s);
        int done_t = -1;
        int n = (s.size == 2'b00) ? 8 : ((s.size == 2'b01) ? 16 : 32);
        for (int t = 0; t < 45; t++) begin
            bit req_on = (t == 0) || s.hold;
            bit busy_m = (cur_kind() >= 1) && (cur_kind() <= 4);
            mul_req_h    = req_on && (s.kind == 1 || s.kind == 7);
            div_req_h    = req_on && (s.kind == 2 || s.kind == 7);
            divdbl_req_h = req_on && (s.kind == 3 || s.kind == 7);
            rem_req_h    = s.rem;
            size_h       = s.size;
            q_lsb_h      = s.early ? 1'b0 : 1'($urandom);
            q_zero_h     = s.early && (t >= 3);
            alu_sout_h   = (t == n) ? 1'b1 : 1'($urandom);
            abort_h      = (s.abort_at > 0) && busy_m && (m_step == s.abort_at);
            reset_h      = (s.reset_at > 0) && busy_m && (m_step == s.reset_at);
            tick();
            if (obs_rem) begin
                total++;
                if (obs_aluso !== 1'b1) begin
                    bad++;
                    $display("FAIL scn%0d fix_aluso got=%0b exp=1", idx, obs_aluso);
                end
            end
            if (obs_done) begin
                done_t = t;
                break;
            end
            if (t > 0 && cur_kind() == 0) break;
        end
        {mul_req_h, div_req_h, divdbl_req_h, rem_req_h, abort_h, reset_h, q_zero_h} = '0;
        tick();
        total++;
        if (done_t != s.exp_done) begin
            bad++;
            $display("FAIL scn%0d done_cycle got=%0d exp=%0d", idx, done_t, s.exp_done);
        end
        total++;
        if (obs_step != s.exp_step) begin
            bad++;
            $display("FAIL scn%0d step_h got=%0d exp=%0d", idx, obs_step, s.exp_step);
        end
    endtask

    initial begin
        scns[0] = '{1, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, 33, 32};               // long multiply
        scns[1] = '{2, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0, 10, 8};                // byte divide + rem
        scns[2] = '{7, 2'b01, 1'b0, 1'b1, 1'b0, 0, 0, 17, 16};               // priority, held reqs
        scns[3] = '{1, 2'b01, 1'b0, 1'b0, 1'b0, 5, 0, -1, 5};                // abort at step 5
        scns[4] = '{2, 2'b10, 1'b0, 1'b0, 1'b0, 0, 10, -1, 0};               // reset at step 10
        scns[5] = '{1, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0, EO ? 4 : 33, EO ? 3 : 32}; // early-out
        scns[6] = '{3, 2'b11, 1'b1, 1'b0, 1'b0, 0, 0, 34, 32};               // size 11 divdbl + rem
        scns[7] = '{1, 2'b01, 1'b1, 1'b0, 1'b0, 0, 0, 17, 16};               // rem ignored for mul
        scns[8] = '{1, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 9, 8};                 // byte multiply

        reset_h = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset_h = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_scn(i, scns[i]);

        for (int i = 0; i < 1500; i++) begin
            mul_req_h    = ($urandom % 4) == 0;
            div_req_h    = ($urandom % 5) == 0;
            divdbl_req_h = ($urandom % 6) == 0;
            rem_req_h    = 1'($urandom);
            size_h       = 2'($urandom);
            q_lsb_h      = 1'($urandom);
            q_zero_h     = ($urandom % 4) == 0;
            alu_sout_h   = 1'($urandom);
            abort_h      = ($urandom % 40) == 0;
            reset_h      = ($urandom % 90) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
